// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned MDU_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MDU     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with increment enable; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// multi-cycle MDU stall and memory-wait freeze, plus stall/flush counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             memread_e,
  input  logic             pcsrc_e,
  input  logic             mdu_start_e,
  input  logic             mem_busy,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             srst_d,
  output logic             srst_e,
  output logic             srst_m,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t                 state_q, state_d;
  logic [MDU_CNT_W-1:0]   mcnt_q, mcnt_d;
  logic                   load_use;
  logic                   mdu_stall;
  logic                   run_dec;

  assign load_use = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next state and pipeline control; reset forces the RUN defaults.
  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    en_f      = 1'b1;
    en_d      = 1'b1;
    en_e      = 1'b1;
    en_m      = 1'b1;
    srst_d    = 1'b1;
    srst_e    = 1'b1;
    srst_m    = 1'b1;
    mdu_stall = 1'b0;
    run_dec   = 1'b0;

    if (!arst) begin
      state_d = RUN;
    end else if (mem_busy) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      en_m    = 1'b0;
      state_d = MEMWAIT;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mdu_start_e) begin
            mdu_stall = 1'b1;
            mcnt_d    = MDU_CNT_W'(MDU_LAT - 1);
            state_d   = MDU;
          end else begin
            run_dec = 1'b1;
          end
        end
        MDU: begin
          if (mcnt_q == '0) begin
            state_d = RUN;
          end else begin
            mdu_stall = 1'b1;
            mcnt_d    = mcnt_q - MDU_CNT_W'(1);
          end
        end
        MEMWAIT: begin
          // Resuming an interrupted MDU op keeps Execute held so it cannot leak.
          if (mcnt_q != '0) begin
            mdu_stall = 1'b1;
            mcnt_d    = mcnt_q - MDU_CNT_W'(1);
            state_d   = MDU;
          end else begin
            run_dec = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (mdu_stall) begin
      en_f   = 1'b0;
      en_d   = 1'b0;
      en_e   = 1'b0;
      srst_m = 1'b0;
    end

    // A taken branch squashes the younger instructions, making load-use moot.
    if (run_dec) begin
      if (pcsrc_e) begin
        srst_d = 1'b0;
        srst_e = 1'b0;
      end else if (load_use) begin
        en_f   = 1'b0;
        en_d   = 1'b0;
        srst_e = 1'b0;
      end
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (!en_f),
    .cnt  (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (!srst_d),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MDU_LAT = 4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 32;
  // Control vector order: {en_f, en_d, en_e, en_m, srst_d, srst_e, srst_m}
  localparam logic [6:0] DEF  = 7'b1111111;
  localparam logic [6:0] LU   = 7'b0011101;
  localparam logic [6:0] BR   = 7'b1111001;
  localparam logic [6:0] MDUS = 7'b0001110;
  localparam logic [6:0] MEMS = 7'b0000111;

  logic             clk = 1'b0;
  logic             arst;
  logic [4:0]       rs1_d, rs2_d, rd_e;
  logic             memread_e, pcsrc_e, mdu_start_e, mem_busy;
  logic             en_f, en_d, en_e, en_m, srst_d, srst_e, srst_m;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       ctl;

  typedef struct {
    logic [6:0] ctl;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  assign ctl = {en_f, en_d, en_e, en_m, srst_d, srst_e, srst_m};

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .arst        (arst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_e        (rd_e),
    .memread_e   (memread_e),
    .pcsrc_e     (pcsrc_e),
    .mdu_start_e (mdu_start_e),
    .mem_busy    (mem_busy),
    .en_f        (en_f),
    .en_d        (en_d),
    .en_e        (en_e),
    .en_m        (en_m),
    .srst_d      (srst_d),
    .srst_e      (srst_e),
    .srst_m      (srst_m),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic pc, input logic ms, input logic mb);
    memread_e   = mr;
    rd_e        = rd;
    rs1_d       = r1;
    rs2_d       = r2;
    pcsrc_e     = pc;
    mdu_start_e = ms;
    mem_busy    = mb;
  endtask

  task automatic check_ctl();
    exp_t e;
    e = sb.pop_front();
    ncmp++;
    assert (ctl === e.ctl) else begin
      nerr++;
      $error("FAIL %s ctl observed %b expected %b", e.tag, ctl, e.ctl);
    end
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef,
                           input string tag);
    ncmp++;
    assert (stall_cnt === es) else begin
      nerr++;
      $error("FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, es);
    end
    ncmp++;
    assert (flush_cnt === ef) else begin
      nerr++;
      $error("FAIL %s flush_cnt observed %0d expected %0d", tag, flush_cnt, ef);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare combinational controls at negedge.
  task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic pc, input logic ms, input logic mb,
                     input logic [6:0] exp, input string tag);
    exp_t e;
    drive(mr, rd, r1, r2, pc, ms, mb);
    e.ctl = exp;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    check_ctl();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [6:0] exp, input string tag);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  // Reset with hazard inputs present: controls must still show RUN defaults.
  task automatic do_reset(input string tag);
    exp_t e;
    arst = 1'b0;
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    e.ctl = DEF;
    e.tag = tag;
    sb.push_back(e);
    check_ctl();
    check_cnt('0, '0, tag);
    @(posedge clk);
    #1;
    arst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    arst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Load-use on rs2
    do_reset("rst0");
    idle(DEF, "idle0");
    cyc(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, LU, "lu_rs2");
    idle(DEF, "lu_after");
    check_cnt(32'd1, 32'd0, "lu_cnt");

    // Load-use on rs1, then load to x0 never stalls
    cyc(1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, LU, "lu_rs1");
    cyc(1'b1, 5'd4, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0, DEF, "load_nodep");
    do_reset("rst_x0");
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, "x0_load");
    check_cnt(32'd0, 32'd0, "x0_cnt");

    // Branch with simultaneous load-use
    do_reset("rst_br");
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, BR, "br_lu");
    idle(DEF, "br_after");
    check_cnt(32'd0, 32'd1, "br_cnt");

    // MDU stall of 4 cycles; start and branch ignored while busy
    do_reset("rst_mdu");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDUS, "mdu_start");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDUS, "mdu_c2");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, MDUS, "mdu_c3");
    idle(MDUS, "mdu_c4");
    idle(DEF, "mdu_exit");
    idle(DEF, "mdu_after");
    check_cnt(32'd4, 32'd0, "mdu_cnt");

    // mem_busy for 3 cycles starting at MDU cycle 2 of 4
    do_reset("rst_mw");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDUS, "mw_start");
    idle(MDUS, "mw_c2");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MEMS, "mw_busy1");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MEMS, "mw_busy2");
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, MEMS, "mw_busy3");
    idle(MDUS, "mw_rem1");
    idle(MDUS, "mw_rem2");
    idle(DEF, "mw_exit");
    check_cnt(32'd7, 32'd0, "mw_cnt");

    // mem_busy outranks branch and load-use; leaving MEMWAIT resumes decode
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, MEMS, "mb_prio");
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, LU, "mb_exit_lu");
    idle(DEF, "mb_after");
    check_cnt(32'd9, 32'd0, "mb_cnt");

    // Reset mid-MDU aborts with no residual stall
    do_reset("rst_ab");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDUS, "ab_start");
    idle(MDUS, "ab_c2");
    do_reset("ab_rst");
    idle(DEF, "ab_after");
    check_cnt(32'd0, 32'd0, "ab_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_LAT, default 4, giving the multi-cycle multiply/divide busy length in cycles (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 arst  input  1  asynchronous, active-low reset.
REQ-005 rs1_d, rs2_d  input  5 each  source registers of the instruction in Decode.
REQ-006 rd_e  input  5  destination register of the instruction in Execute.
REQ-007 memread_e  input  1  the instruction in Execute is a load.
REQ-008 pcsrc_e  input  1  a taken branch or jump resolves in Execute.
REQ-009 mdu_start_e  input  1  a multi-cycle MDU operation enters Execute.
REQ-010 mem_busy  input  1  data memory is not ready this cycle.
REQ-011 en_f, en_d, en_e, en_m  output  1 each  enables for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers; 1 means load.
REQ-012 srst_d, srst_e, srst_m  output  1 each  active-low synchronous clears for the IF/ID, ID/EX and EX/MEM registers; 0 means insert a bubble.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-014 The FSM SHALL have three states: RUN, MDU and MEMWAIT.
REQ-015 The en_* and srst_* outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-016 Default outputs in RUN, when no hazard is present: all en_* = 1 and all srst_* = 1.
REQ-017 Priority when hazards coincide, highest first: mem_busy, MDU busy, pcsrc_e, load-use.
REQ-018 mem_busy = 1 in any state: en_f, en_d, en_e and en_m SHALL all be 0; srst_* SHALL all be 1; the state SHALL go to MEMWAIT; the MDU counter SHALL freeze.
REQ-019 MEMWAIT: the FSM SHALL stay in MEMWAIT while mem_busy = 1; on mem_busy = 0 it SHALL return to MDU if the counter is nonzero, otherwise to RUN.
REQ-020 mdu_start_e in RUN: the counter SHALL load MDU_LAT-1 and the state SHALL go to MDU next cycle; in that start cycle en_f, en_d and en_e SHALL be 0 and srst_m SHALL be 0.
REQ-021 MDU: en_f, en_d and en_e SHALL be 0 and srst_m SHALL be 0 every cycle; the counter SHALL decrement each cycle.
REQ-022 MDU exit: when the counter reaches 0, outputs SHALL be the RUN defaults in that cycle and the state SHALL go to RUN; total stall is exactly MDU_LAT cycles.
REQ-023 mdu_start_e SHALL be ignored while in the MDU or MEMWAIT states.
REQ-024 Branch, pcsrc_e in RUN: srst_d = 0 and srst_e = 0; all en_* SHALL be 1.
REQ-025 A load-use hazard occurring together with pcsrc_e SHALL be suppressed.
REQ-026 Load-use is defined as memread_e and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d).
REQ-027 Load-use response: en_f = 0, en_d = 0 and srst_e = 0 for exactly one cycle.
REQ-028 rd_e = 0 SHALL never produce a load-use stall.
REQ-029 stall_cnt SHALL increment by one on every cycle in which en_f = 0.
REQ-030 flush_cnt SHALL increment by one on every cycle in which srst_d = 0.
REQ-031 Both counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-032 arst = 0 SHALL immediately force the state to RUN, the MDU counter to 0, and stall_cnt and flush_cnt to 0.
REQ-033 While arst = 0, the en_* and srst_* outputs SHALL equal the RUN defaults.
REQ-034 Reset asserted mid-MDU or mid-MEMWAIT SHALL abort the operation with no residual stall after release.
REQ-035 The block SHALL have no synchronous reset input; pipeline-register clearing is done only via the srst_* outputs.

Structure
REQ-036 The state enum (RUN, MDU, MEMWAIT) and the register-index width constant (5) SHALL live in the shared package hazard_pkg.
REQ-037 The two counters SHALL be two instances of one sub-module, perf_counter (CNT_W wide, async active-low reset, increment enable).
REQ-038 The FSM and the hazard decode SHALL live in the top module.

Verification
REQ-039 Load-use: memread_e = 1, rd_e = 5, rs2_d = 5 for one cycle -> en_f = en_d = 0 and srst_e = 0 for 1 cycle; stall_cnt = 1.
REQ-040 x0 load: memread_e = 1, rd_e = 0, rs1_d = 0 -> RUN defaults; stall_cnt = 0.
REQ-041 Branch plus load-use in the same cycle -> srst_d = srst_e = 0, en_f = 1; flush_cnt = 1; stall_cnt = 0.
REQ-042 mdu_start_e with MDU_LAT = 4 -> en_f = 0 and srst_m = 0 for exactly 4 cycles; stall_cnt = 4.
REQ-043 mem_busy high for 3 cycles during MDU cycle 2 -> all en_* = 0 for those 3 cycles; the MDU then completes its remaining 2 cycles; stall_cnt = 7.
REQ-044 arst pulsed low during MDU cycle 2 -> the next cycle after release shows RUN defaults with both counters = 0.
